// File: rtl/tb_irq_timer_responder.sv
// Bus-attached interrupt responder for directed core tests: a reloadable countdown
// timer plus software set/clear of a 32-bit pending vector that the core acknowledges.
module tb_irq_timer_responder #(
  parameter logic [31:0] BASE_ADDR     = 32'h1500_0000,
  parameter int unsigned TIMER_IRQ_BIT = 7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic [31:0] irq_o,
  input  logic        irq_ack_i,
  input  logic [4:0]  irq_id_i
);

  typedef enum logic [1:0] {
    REG_CMP   = 2'd0,
    REG_CTRL  = 2'd1,
    REG_PEND  = 2'd2,
    REG_COUNT = 2'd3
  } reg_e;

  localparam logic [31:0] TIMER_BIT_MASK = 32'd1 << TIMER_IRQ_BIT;

  logic [31:0] cmp_q, cmp_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] rdata_q, rdata_d;
  logic        en_q, en_d;
  logic        auto_q, auto_d;
  logic        rvalid_q, rvalid_d;

  logic        hit, wr_en, expire;
  reg_e        offset;
  logic [31:0] byte_mask, wr_bits, set_vec, clr_vec;
  logic [1:0]  unused_addr_bits;

  assign unused_addr_bits = data_addr_i[1:0];

  always_comb begin
    hit       = data_req_i && (data_addr_i[31:4] == BASE_ADDR[31:4]);
    wr_en     = hit && data_we_i;
    offset    = reg_e'(data_addr_i[3:2]);
    byte_mask = {{8{data_be_i[3]}}, {8{data_be_i[2]}}, {8{data_be_i[1]}}, {8{data_be_i[0]}}};
    wr_bits   = data_wdata_i & byte_mask;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    cmp_d   = cmp_q;
    en_d    = en_q;
    auto_d  = auto_q;
    count_d = count_q;
    expire  = 1'b0;
    set_vec = '0;
    clr_vec = irq_ack_i ? (32'd1 << irq_id_i) : '0;

    if (en_q && (count_q != '0)) begin
      if (count_q == 32'd1) begin
        expire  = 1'b1;
        count_d = auto_q ? cmp_q : '0;
      end else begin
        count_d = count_q - 32'd1;
      end
    end
    if (expire) set_vec = TIMER_BIT_MASK;

    // Register writes come after the timer so their COUNT loads override a tick.
    if (wr_en) begin
      unique case (offset)
        REG_CMP: begin
          cmp_d   = (cmp_q & ~byte_mask) | wr_bits;
          count_d = cmp_d;
        end
        REG_CTRL: if (data_be_i[0]) begin
          en_d   = data_wdata_i[0];
          auto_d = data_wdata_i[1];
          if (!en_q && data_wdata_i[0]) count_d = cmp_q;
        end
        REG_PEND:  set_vec = set_vec | wr_bits;
        REG_COUNT: clr_vec = clr_vec | wr_bits;
        default: ;
      endcase
    end

    // Clears are applied first so a coincident set always wins.
    pending_d = (pending_q & ~clr_vec) | set_vec;

    rvalid_d = hit;
    rdata_d  = '0;
    if (hit && !data_we_i) begin
      unique case (offset)
        REG_CMP:   rdata_d = cmp_q;
        REG_CTRL:  rdata_d = {30'd0, auto_q, en_q};
        REG_PEND:  rdata_d = pending_q;
        REG_COUNT: rdata_d = count_q;
        default:   rdata_d = '0;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmp_q     <= '0;
      en_q      <= 1'b0;
      auto_q    <= 1'b0;
      count_q   <= '0;
      pending_q <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      cmp_q     <= cmp_d;
      en_q      <= en_d;
      auto_q    <= auto_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign irq_o         = pending_q;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;

endmodule

// File: tb/tb_tb_irq_timer_responder.sv
// Scoreboard bench: the driver predicts each bus response from a register-level model
// and queues it; a monitor retires responses and checks irq_o after every edge.
module tb_tb_irq_timer_responder;

  localparam logic [31:0] BASE_ADDR     = 32'h1500_0000;
  localparam int unsigned TIMER_IRQ_BIT = 7;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic [31:0] irq_o;
  logic        irq_ack_i;
  logic [4:0]  irq_id_i;

  tb_irq_timer_responder #(
    .BASE_ADDR    (BASE_ADDR),
    .TIMER_IRQ_BIT(TIMER_IRQ_BIT)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .data_req_i   (data_req_i),
    .data_addr_i  (data_addr_i),
    .data_we_i    (data_we_i),
    .data_be_i    (data_be_i),
    .data_wdata_i (data_wdata_i),
    .data_rvalid_o(data_rvalid_o),
    .data_rdata_o (data_rdata_o),
    .irq_o        (irq_o),
    .irq_ack_i    (irq_ack_i),
    .irq_id_i     (irq_id_i)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  // Register-level reference state, always holding the value expected after the next edge.
  logic [31:0] m_cmp = '0, m_count = '0, m_pending = '0;
  logic        m_en = 1'b0, m_auto = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cmp = '0; m_count = '0; m_pending = '0; m_en = 1'b0; m_auto = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic req, input logic [31:0] addr, input logic we,
                            input logic [3:0] be, input logic [31:0] wdata,
                            input logic ack, input logic [4:0] id);
    logic        hit;
    logic [1:0]  off;
    logic [31:0] mask, bits, set_v, clr_v, next_count;
    hit  = req && (addr[31:4] == BASE_ADDR[31:4]);
    off  = addr[3:2];
    mask = '0;
    for (int b = 0; b < 4; b++) if (be[b]) mask = mask | (32'hFF << (8 * b));
    bits = wdata & mask;
    if (hit) begin
      if (we) exp_q.push_back('0);
      else case (off)
        2'd0: exp_q.push_back(m_cmp);
        2'd1: exp_q.push_back({30'd0, m_auto, m_en});
        2'd2: exp_q.push_back(m_pending);
        default: exp_q.push_back(m_count);
      endcase
    end
    set_v = '0;
    clr_v = ack ? (32'd1 << id) : '0;
    next_count = m_count;
    if (m_en && m_count != 0) begin
      next_count = m_count - 1;
      if (next_count == 0) begin
        set_v[TIMER_IRQ_BIT] = 1'b1;
        if (m_auto) next_count = m_cmp;
      end
    end
    if (hit && we) case (off)
      2'd0: begin m_cmp = (m_cmp & ~mask) | bits; next_count = m_cmp; end
      2'd1: if (be[0]) begin
        if (!m_en && wdata[0]) next_count = m_cmp;
        m_en = wdata[0]; m_auto = wdata[1];
      end
      2'd2: set_v = set_v | bits;
      default: clr_v = clr_v | bits;
    endcase
    m_count   = next_count;
    m_pending = (m_pending & ~clr_v) | set_v;
  endtask

  task automatic cycle(input logic req, input logic [31:0] addr, input logic we,
                       input logic [3:0] be, input logic [31:0] wdata,
                       input logic ack, input logic [4:0] id);
    @(negedge clk_i);
    data_req_i = req; data_addr_i = addr; data_we_i = we; data_be_i = be;
    data_wdata_i = wdata; irq_ack_i = ack; irq_id_i = id;
    model_edge(req, addr, we, be, wdata, ack, id);
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d, input logic [3:0] be);
    cycle(1'b1, BASE_ADDR | {28'd0, off, 2'b00}, 1'b1, be, d, 1'b0, 5'd0);
  endtask
  task automatic rd(input logic [1:0] off);
    cycle(1'b1, BASE_ADDR | {28'd0, off, 2'b00}, 1'b0, 4'hF, 32'hDEAD_BEEF, 1'b0, 5'd0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 4'h0, '0, 1'b0, 5'd0);
  endtask

  always @(posedge clk_i) begin
    #1;
    if (!rst_i) begin
      check("irq_o", irq_o, m_pending);
      if (exp_q.size() > 0) begin
        check("rvalid", {31'd0, data_rvalid_o}, 32'd1);
        check("rdata", data_rdata_o, exp_q.pop_front());
      end else begin
        check("rvalid_idle", {31'd0, data_rvalid_o}, 32'd0);
        check("rdata_idle", data_rdata_o, 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running, expected finished");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    logic found;
    rst_i = 1'b1; data_req_i = 1'b0; data_addr_i = '0; data_we_i = 1'b0;
    data_be_i = '0; data_wdata_i = '0; irq_ack_i = 1'b0; irq_id_i = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    for (int r = 0; r < 4; r++) rd(2'(r));

    // One-shot: expiry exactly five edges after the CMP write, then no repeat.
    wr(2'd1, 32'h1, 4'hF);
    wr(2'd0, 32'd5, 4'hF);
    idle(4);
    @(posedge clk_i); #2 check("oneshot_before", irq_o, 32'h0);
    idle(1);
    @(posedge clk_i); #2 check("oneshot_fire", irq_o, 32'h80);
    rd(2'd3);
    wr(2'd3, 32'h80, 4'hF);
    idle(10);
    @(posedge clk_i); #2 check("oneshot_no_repeat", irq_o, 32'h0);

    // Auto-reload with acks, including an ack that lands on an expiry edge.
    wr(2'd0, 32'd4, 4'hF);
    wr(2'd1, 32'h3, 4'hF);
    idle(9);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_pending[TIMER_IRQ_BIT] && m_count > 1) found = 1'b1;
      else idle(1);
    end
    check("ack_window", {31'd0, found}, 32'd1);
    cycle(1'b0, '0, 1'b0, 4'h0, '0, 1'b1, 5'd7);
    @(posedge clk_i); #2 check("ack_clears", {31'd0, irq_o[7]}, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_count == 1) found = 1'b1;
      else idle(1);
    end
    check("expiry_window", {31'd0, found}, 32'd1);
    cycle(1'b0, '0, 1'b0, 4'h0, '0, 1'b1, 5'd7);
    @(posedge clk_i); #2 check("ack_vs_expiry", {31'd0, irq_o[7]}, 32'd1);

    // Byte-masked SET/CLR and an all-zero byte enable.
    wr(2'd1, 32'h0, 4'hF);
    wr(2'd3, 32'hFFFF_FFFF, 4'hF);
    wr(2'd2, 32'hFFFF_0808, 4'b0011);
    @(posedge clk_i); #2 check("set_masked", irq_o, 32'h0000_0808);
    wr(2'd3, 32'h0000_0800, 4'hF);
    @(posedge clk_i); #2 check("clr_masked", irq_o, 32'h0000_0008);
    wr(2'd2, 32'hFFFF_FFFF, 4'h0);
    @(posedge clk_i); #2 check("be_zero", irq_o, 32'h0000_0008);

    // Out-of-window write, then back-to-back reads.
    cycle(1'b1, BASE_ADDR + 32'h18, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0, 5'd0);
    @(posedge clk_i); #2 check("decode_miss", irq_o, 32'h0000_0008);
    rd(2'd2);
    rd(2'd3);

    // EN gating: count freezes while disabled and reloads from CMP on re-enable.
    wr(2'd0, 32'd10, 4'hF);
    wr(2'd1, 32'h1, 4'hF);
    idle(3);
    wr(2'd1, 32'h0, 4'hF);
    rd(2'd3);
    idle(10);
    rd(2'd3);
    wr(2'd1, 32'h1, 4'hF);
    rd(2'd3);

    // Asynchronous reset mid-countdown with a read in flight.
    wr(2'd0, 32'd6, 4'hF);
    wr(2'd1, 32'h3, 4'hF);
    wr(2'd2, 32'hF0, 4'hF);
    rd(2'd2);
    rd(2'd3);
    #2 rst_i = 1'b1;
    #1;
    check("rst_rvalid", {31'd0, data_rvalid_o}, 32'd0);
    check("rst_rdata", data_rdata_o, 32'd0);
    check("rst_irq", irq_o, 32'd0);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0; data_req_i = 1'b0; irq_ack_i = 1'b0;
    for (int r = 0; r < 4; r++) rd(2'(r));

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] a, d;
      logic [1:0]  off;
      int          r;
      off = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 99);
      if (r < 85) a = BASE_ADDR | {28'd0, off, 2'($urandom_range(0, 3))};
      else if (r < 93) a = BASE_ADDR + 32'h10 + {28'd0, off, 2'b00};
      else a = $urandom;
      case (off)
        2'd0: d = 32'($urandom_range(0, 12));
        2'd1: d = $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom;
        default: d = $urandom & $urandom;
      endcase
      cycle(($urandom_range(0, 5) != 0), a, 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), d, ($urandom_range(0, 4) == 0),
            $urandom_range(0, 1) ? 5'd7 : 5'($urandom_range(0, 31)));
    end

    idle(2);
    @(posedge clk_i); #2 check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
